// File: rtl/jk_timer_pkg.sv
// Shared constants for the JK-flip-flop based down timer.
package jk_timer_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counting mode selected by the mode input
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // What the JK inputs of the count bits do on the next edge
    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_DEC  = 2'd2;

endpackage

// File: rtl/jk_ff_ar.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_ff_ar (
    input  logic clk,
    input  logic rst_n,
    input  logic J,
    input  logic K,
    output logic Q
);

    // Standard JK behaviour: hold, reset, set, toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                2'b00:   Q <= Q;
                2'b01:   Q <= 1'b0;
                2'b10:   Q <= 1'b1;
                default: Q <= ~Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_down_timer.sv
// Programmable down-counting timer: one-shot or auto-reload, built from
// JK flip-flops with a registered terminal-count pulse and sticky done flag.
module jk_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);
    import jk_timer_pkg::*;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] next_reload;
    logic             next_tc;
    logic             next_done;
    logic [1:0]       jk_op;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] jk_j;
    logic [WIDTH-1:0] jk_k;
    logic [WIDTH-1:0] count;

    assign q    = count;
    assign busy = (state == ST_RUN);

    // Control decisions in priority order: load, then start, then counting
    always_comb begin
        next_state  = state;
        next_reload = reload;
        next_done   = done;
        next_tc     = 1'b0;
        jk_op       = OP_HOLD;
        load_data   = '0;
        if (load) begin
            next_reload = load_val;
            load_data   = load_val;
            jk_op       = OP_LOAD;
            next_state  = ST_IDLE;
            next_done   = 1'b0;
        end else if (start && (state != ST_RUN)) begin
            jk_op = OP_LOAD;
            if (reload != '0) begin
                load_data  = reload;
                next_state = ST_RUN;
                next_done  = 1'b0;
            end else begin
                load_data  = '0;
                next_state = ST_DONE;
                next_done  = 1'b1;
                next_tc    = 1'b1;
            end
        end else if ((state == ST_RUN) && en) begin
            if (count > ONE) begin
                jk_op = OP_DEC;
            end else if (mode == MODE_ONESHOT) begin
                jk_op      = OP_LOAD;
                load_data  = '0;
                next_state = ST_DONE;
                next_done  = 1'b1;
                next_tc    = 1'b1;
            end else begin
                jk_op     = OP_LOAD;
                load_data = reload;
                next_tc   = 1'b1;
            end
        end
    end

    // Borrow chain: a bit toggles when every lower bit is zero
    always_comb begin
        toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & ~count[i-1];
        end
    end

    // Translate the selected operation into per-bit J/K inputs
    always_comb begin
        jk_j = '0;
        jk_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (jk_op)
                OP_DEC: begin
                    jk_j[i] = toggle[i];
                    jk_k[i] = toggle[i];
                end
                OP_LOAD: begin
                    jk_j[i] = load_data[i];
                    jk_k[i] = ~load_data[i];
                end
                default: begin
                    jk_j[i] = 1'b0;
                    jk_k[i] = 1'b0;
                end
            endcase
        end
    end

    // Controller state, reload value and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            reload <= '0;
            tc     <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= next_state;
            reload <= next_reload;
            tc     <= next_tc;
            done   <= next_done;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_ff_ar u_ff (
                .clk   (clk),
                .rst_n (rst_n),
                .J     (jk_j[gi]),
                .K     (jk_k[gi]),
                .Q     (count[gi])
            );
        end
    endgenerate

endmodule
